// File: rtl/ma_load_unit_if.sv
// Handshake and bus bundle between the MA stage/LSU and the load completion unit.
// master = MA stage / LSU side, slave = ma_load_unit.
interface ma_load_unit_if #(
  parameter int unsigned CE_CNT_W = 8
);
  logic                s_flush_i;
  logic                s_req_i;
  logic [2:0]          s_funct_i;
  logic [1:0]          s_addr_i;
  logic                s_dp_ready_i;
  logic                s_dp_hresp_i;
  logic                s_dp_save_i;
  logic [31:0]         s_dp_data_i;
  logic [31:0]         s_fixed_data_i;
  logic [1:0]          s_einfo_i;
  logic                s_wb_ready_i;
  logic [31:0]         s_read_data_o;
  logic                s_wb_valid_o;
  logic [31:0]         s_wb_data_o;
  logic                s_exc_o;
  logic [1:0]          s_exc_cause_o;
  logic                s_stall_o;
  logic [CE_CNT_W-1:0] s_ce_cnt_o;

  modport master (
    output s_flush_i, s_req_i, s_funct_i, s_addr_i, s_dp_ready_i, s_dp_hresp_i,
           s_dp_save_i, s_dp_data_i, s_fixed_data_i, s_einfo_i, s_wb_ready_i,
    input  s_read_data_o, s_wb_valid_o, s_wb_data_o, s_exc_o, s_exc_cause_o,
           s_stall_o, s_ce_cnt_o
  );

  modport slave (
    input  s_flush_i, s_req_i, s_funct_i, s_addr_i, s_dp_ready_i, s_dp_hresp_i,
           s_dp_save_i, s_dp_data_i, s_fixed_data_i, s_einfo_i, s_wb_ready_i,
    output s_read_data_o, s_wb_valid_o, s_wb_data_o, s_exc_o, s_exc_cause_o,
           s_stall_o, s_ce_cnt_o
  );
endinterface

// File: rtl/ma_load_unit.sv
// Load completion unit: captures the bus word, takes the SECDED-corrected word back,
// then aligns/extends it and presents it (or an exception) to write-back.
module ma_load_unit #(
  parameter int unsigned CE_CNT_W = 8
) (
  input  logic           s_clk_i,
  input  logic           s_rst_i,
  ma_load_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

  state_e              state_q, state_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                wb_valid_q, wb_valid_d;
  logic                exc_q, exc_d;
  logic [1:0]          cause_q, cause_d;
  logic [CE_CNT_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [2:0]          funct_q, funct_d;
  logic [1:0]          addr_q, addr_d;

  logic                misaligned;
  logic [31:0]         shifted;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         fmt_data;

  always_comb begin
    unique case (bus.s_funct_i[1:0])
      2'b01:   misaligned = bus.s_addr_i[0];
      2'b10:   misaligned = |bus.s_addr_i;
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Formatting uses size/offset latched at capture, since the corrected word
  // arrives one cycle after the data phase.
  always_comb begin
    shifted = bus.s_fixed_data_i >> {addr_q, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_q[1] ? bus.s_fixed_data_i[31:16] : bus.s_fixed_data_i[15:0];
    unique case (funct_q[1:0])
      2'b00:   fmt_data = {{24{byte_v[7] & ~funct_q[2]}}, byte_v};
      2'b01:   fmt_data = {{16{half_v[15] & ~funct_q[2]}}, half_v};
      default: fmt_data = bus.s_fixed_data_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = wb_valid_q;
    exc_d       = exc_q;
    cause_d     = cause_q;
    ce_cnt_d    = ce_cnt_q;
    funct_d     = funct_q;
    addr_d      = addr_q;
    if (bus.s_flush_i) begin
      state_d    = IDLE;
      wb_valid_d = 1'b0;
      exc_d      = 1'b0;
      cause_d    = 2'b00;
      wb_data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.s_req_i) begin
            if (misaligned) begin
              state_d    = RESP;
              wb_valid_d = 1'b1;
              exc_d      = 1'b1;
              cause_d    = 2'b11;
              wb_data_d  = '0;
            end else if (bus.s_dp_ready_i && bus.s_dp_hresp_i) begin
              state_d    = RESP;
              wb_valid_d = 1'b1;
              exc_d      = 1'b1;
              cause_d    = 2'b01;
              wb_data_d  = '0;
            end else if (bus.s_dp_ready_i && bus.s_dp_save_i) begin
              state_d     = CHECK;
              read_data_d = bus.s_dp_data_i;
              funct_d     = bus.s_funct_i;
              addr_d      = bus.s_addr_i;
            end
          end
        end
        CHECK: begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          if (bus.s_einfo_i[0]) begin
            exc_d     = 1'b1;
            cause_d   = 2'b10;
            wb_data_d = '0;
          end else begin
            exc_d     = 1'b0;
            cause_d   = 2'b00;
            wb_data_d = fmt_data;
            if (bus.s_einfo_i[1] && (ce_cnt_q != '1))
              ce_cnt_d = ce_cnt_q + CE_CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.s_wb_ready_i) begin
            state_d    = IDLE;
            wb_valid_d = 1'b0;
            exc_d      = 1'b0;
            cause_d    = 2'b00;
            wb_data_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      exc_q       <= 1'b0;
      cause_q     <= 2'b00;
      ce_cnt_q    <= '0;
      funct_q     <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      wb_data_q   <= wb_data_d;
      wb_valid_q  <= wb_valid_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
      ce_cnt_q    <= ce_cnt_d;
      funct_q     <= funct_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.s_read_data_o = read_data_q;
  assign bus.s_wb_valid_o  = wb_valid_q;
  assign bus.s_wb_data_o   = wb_data_q;
  assign bus.s_exc_o       = exc_q;
  assign bus.s_exc_cause_o = cause_q;
  assign bus.s_ce_cnt_o    = ce_cnt_q;
  assign bus.s_stall_o     = bus.s_req_i & ~((state_q == RESP) & bus.s_wb_ready_i);
endmodule

// File: doc/ma_load_unit.md
# ma_load_unit

Memory-access-stage load completion unit, directly downstream of the LSU data phase. Captures the word returned on the data bus and hands the raw word back to the LSU for SECDED decoding. Takes the corrected word and error info one cycle later, then selects, aligns and sign/zero-extends the loaded value. Presents the result to write-back with a valid/ready handshake and reports bus, uncorrectable-EDAC and misalignment exceptions.

## Interface
- CE_CNT_W, 8, width of the saturating corrected-error counter

- s_clk_i  in  1  clock
- s_rst_i  in  1  reset, asynchronous, active-high
- s_flush_i  in  1  pipeline flush; aborts any load in progress
- s_req_i  in  1  MA stage holds a valid load in its data phase
- s_funct_i  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] unsigned
- s_addr_i  in  2  load address bits [1:0]
- s_dp_ready_i  in  1  data-phase ready (bus hready)
- s_dp_hresp_i  in  1  registered bus error for the current data phase
- s_dp_save_i  in  1  bus data of this cycle must be captured
- s_dp_data_i  in  32  bus read data
- s_fixed_data_i  in  32  corrected version of s_read_data_o from the LSU
- s_einfo_i  in  2  {ce, ue} for s_read_data_o
- s_wb_ready_i  in  1  write-back accepts the result
- s_read_data_o  out  32  captured raw bus word
- s_wb_valid_o  out  1  result or exception valid
- s_wb_data_o  out  32  formatted load value
- s_exc_o  out  1  result carries an exception
- s_exc_cause_o  out  2  01 bus error, 10 uncorrectable EDAC, 11 misaligned/illegal size
- s_stall_o  out  1  MA stage must hold
- s_ce_cnt_o  out  CE_CNT_W  corrected-error count, saturating

## Operation
- FSM states:
  - IDLE: waiting for a load, or waiting for bus data.
  - CHECK: the captured word is being decoded by the LSU; s_einfo_i and s_fixed_data_i are valid this cycle.
  - RESP: the result is held for write-back.
- IDLE, s_req_i=1, evaluated in priority order:
  - Misaligned (half with addr[0]=1; word with addr!=00) or size=11 -> RESP, exc cause 11, no bus capture.
  - Else if s_dp_ready_i and s_dp_hresp_i -> RESP, exc cause 01.
  - Else if s_dp_ready_i and s_dp_save_i -> register s_dp_data_i into s_read_data_o -> CHECK.
  - Else stay in IDLE (wait states).
- CHECK:
  - ue=1 -> RESP, exc cause 10, data 0.
  - Otherwise format s_fixed_data_i -> RESP.
  - ce=1 with ue=0 increments s_ce_cnt_o; it saturates at all ones.
- RESP: s_wb_valid_o=1. When s_wb_ready_i=1 -> IDLE. A back-to-back s_req_i is evaluated from IDLE the next cycle.
- Formatting:
  - Byte: lane addr[1:0].
  - Half: bits [31:16] if addr[1], else [15:0].
  - Word: unchanged.
  - Bits above the loaded width are filled with the sign bit, or with zeros if funct[2]=1.
- s_exc_o=1 forces s_wb_data_o=0.
- Flush: highest priority in every state. Next state is IDLE; s_wb_valid_o and s_exc_o are cleared next cycle. The counter is not incremented for a flushed CHECK and is not cleared by flush.
- s_read_data_o changes only on capture.

## Timing
- Reset: state IDLE; all outputs 0, including s_ce_cnt_o.
- Minimum load latency: capture in cycle N, CHECK in N+1, s_wb_valid_o in N+2.
- s_stall_o = s_req_i & ~(state==RESP & s_wb_ready_i), combinational.
- s_wb_data_o, s_exc_o and s_exc_cause_o are registered and stable while s_wb_valid_o=1 and s_wb_ready_i=0.
- s_wb_valid_o never asserts without a prior s_req_i. Outputs of a flushed load never reach write-back.
- Reset asserted mid-operation: immediate return to reset values regardless of clock.

## Test plan
- Signed byte load, addr=11, bus word 0x80123456, einfo=00 -> CHECK next cycle, then s_wb_valid_o with s_wb_data_o=0xFFFFFF80, s_exc_o=0.
- Unsigned half load, addr=10, bus word 0xBEEF1234, two wait states (s_dp_ready_i=0 for 2 cycles) -> s_stall_o held throughout, then result 0x0000BEEF.
- Word load with einfo=10 and s_fixed_data_i=0x0000000F differing from raw 0x0000000E -> result 0x0000000F, s_ce_cnt_o 0->1. Repeat 300 times with CE_CNT_W=8 -> counter stops at 255.
- Word load with einfo=01 -> s_exc_o=1, cause 10, data 0. Word load with s_dp_hresp_i=1 at ready -> cause 01, s_read_data_o unchanged.
- Half load at addr=01 -> RESP the next cycle with cause 11, no capture.
- Flush asserted during CHECK with ce=1 -> no s_wb_valid_o, counter unchanged.
- Result held with s_wb_ready_i=0 for 3 cycles -> outputs stable and s_stall_o=1; s_wb_ready_i=1 -> IDLE the next cycle.
- Reset pulse in RESP -> all outputs 0 asynchronously.
